id_stage_ctrl: RTL
==================

# id_stage_ctrl

Decode-stage sequencer between instruction fetch and execute. Accepts fetched instructions over a valid/ready handshake, decodes the opcode into immediate-select and control fields, registers them into the ID/EX boundary, and drives the immediate generator's `imm_sel` and 25-bit instruction field. Handles back-pressure from execute, inserts a one-cycle load-use bubble, and flushes on redirect.

## Interface
- `XLEN`, 32: PC and instruction width.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: redirect; discard the held instruction.
- `if_valid` in 1: fetch offers an instruction.
- `if_ready` out 1: ID accepts this cycle.
- `if_instr` in XLEN: instruction word.
- `if_pc` in XLEN: its PC.
- `ex_ready` in 1: execute accepts this cycle.
- `id_valid` out 1: ID/EX contents valid; low means bubble.
- `id_pc`, `id_instr` out XLEN: held PC and instruction.
- `id_imm_field` out 25: `instr[31:7]`, for the immediate generator.
- `id_imm_sel` out 3: immediate format.
- `id_rs1`, `id_rs2`, `id_rd` out 5: register fields.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_jump`, `id_illegal` out 1: control flags.

## Operation
- Decode on opcode `instr[6:0]`:
  - LUI 0110111 and AUIPC 0010111 → 000 (U).
  - JAL 1101111 → 001 (J).
  - STORE 0100011 → 010 (S).
  - BRANCH 1100011 → 011 (B).
  - LOAD 0000011 and JALR 1100111 → 100 (I).
  - OP-IMM 0010011: funct3 001/101 → 101 (I-shift); funct3 011 → 110 (IU); otherwise → 100.
  - OP 0110011 → 111 (no immediate).
  - Any other opcode → 111 with `id_illegal`=1 and all other flags 0.
- `reg_write` set for U, J, LOAD, JALR, OP-IMM and OP.
- `mem_read` set for LOAD only. `mem_write` set for STORE only.
- `branch` set for BRANCH. `jump` set for JAL and JALR.
- rs1 is used by every opcode except U and J. rs2 is used by STORE, BRANCH and OP.
- FSM states:
  - EMPTY: `id_valid`=0.
  - FULL: `id_valid`=1.
  - STALL: instruction held, `id_valid`=0.
- `if_ready` = !flush && (EMPTY || (FULL && ex_ready)).
- Accept means `if_valid && if_ready`. Hand-off means `id_valid && ex_ready`.
- Transitions (priority order):
  - rst → EMPTY.
  - flush → EMPTY.
  - EMPTY, accept → FULL.
  - FULL, ex_ready and accept → STALL if hazard, else FULL.
  - FULL, ex_ready and no accept → EMPTY.
  - FULL, !ex_ready → hold.
  - STALL, ex_ready → FULL, so the bubble has been consumed downstream. STALL, !ex_ready → hold.
- Hazard: all of the following must be true:
  - the outgoing instruction has `mem_read`;
  - its rd ≠ 0;
  - the incoming instruction uses rs1 with rs1 == rd, or uses rs2 with rs2 == rd.
- Register fields are loaded only on accept and are otherwise held unchanged.
- On reset and on flush:
  - all `id_*` registers clear to 0, except `id_imm_sel`, which becomes 3'b111;
  - state clears to EMPTY.
  - Reset value of `if_ready` is 1 (EMPTY, no flush).

## Timing
- Accept in cycle N → `id_valid`=1 in N+1. With a hazard, `id_valid`=0 in N+1 and 1 in the first cycle after STALL sees `ex_ready`.
- All `id_*` outputs are registered. `if_ready` is combinational from state, `ex_ready` and `flush`.
- Accept and hand-off in the same cycle: full throughput, one instruction per cycle with no hazards.
- A flush coinciding with `if_valid`: the instruction is not accepted (`if_ready`=0). Next cycle: EMPTY.
- Reset mid-stall: STALL abandoned and state returns to EMPTY.

## Configuration
- `ID_LOAD_USE_STALL_EN` defined: hazard detection active, as above.
- Undefined: hazard tied to 0, STALL unreachable. The FSM reduces to EMPTY/FULL; load-use is then resolved downstream.

## Structure
- Package `riscv_id_pkg`:
  - `imm_sel_t` enum: U, J, S, B, I, ISHIFT, IU, NONE = 000–111.
  - Opcode constants.
  - `id_state_t` enum.
  - `id_ctrl_t` struct holding the flags.
- Sub-module `id_decode`: combinational opcode/funct3 → `id_ctrl_t`, `imm_sel`, rs1/rs2 usage.
- The FSM and registers live in the top module.

## Test plan
- Reset, then idle: `if_ready`=1, `id_valid`=0, `id_imm_sel`=111, all flags 0.
- Feed `addi x1,x0,5` (0x00500093) with `ex_ready`=1: next cycle `id_valid`=1, `id_imm_sel`=100, `id_rd`=1, `id_reg_write`=1, `id_imm_field`=0x00A001.
- Back-to-back `lw x5,0(x2)` then `add x6,x5,x1` with `ex_ready`=1:
  - macro on: `id_valid` pattern 1,0,1 with `id_imm_sel` 111 on the third cycle;
  - macro off: pattern 1,1.
- Hold `ex_ready`=0 for 3 cycles while FULL: outputs stable, `if_ready`=0. Release: hand-off and new accept occur the same cycle.
- Assert `flush` while FULL and `if_valid`=1: next cycle `id_valid`=0, state EMPTY, and the offered instruction is not accepted.
- Opcode 0x7F: `id_illegal`=1, `id_imm_sel`=111. Also sweep `slli` → 101, `sltiu` → 110, `jal` → 001, `sw` → 010, `beq` → 011, `lui` → 000.

Source files
------------

// File: rtl/id_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_id_pkg
//  Purpose  : Shared types and constants for the decode-stage sequencer:
//             immediate formats, RV32 base opcodes, sequencer states and
//             the decoded control-flag bundle.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_id_pkg;

    // Immediate format handed to the immediate generator
    typedef enum logic [2:0] {
        IMM_U      = 3'b000,
        IMM_J      = 3'b001,
        IMM_S      = 3'b010,
        IMM_B      = 3'b011,
        IMM_I      = 3'b100,
        IMM_ISHIFT = 3'b101,
        IMM_IU     = 3'b110,
        IMM_NONE   = 3'b111
    } imm_sel_t;

    // RV32 base opcodes (instr[6:0])
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;

    // OP-IMM funct3 values that change the immediate format
    localparam logic [2:0] c_f3_slli  = 3'b001;
    localparam logic [2:0] c_f3_srli  = 3'b101;
    localparam logic [2:0] c_f3_sltiu = 3'b011;

    // ID/EX boundary occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_STALL = 2'd2
    } id_state_t;

    // Control flags travelling with the instruction into execute
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic illegal;
    } id_ctrl_t;

endpackage : riscv_id_pkg
`default_nettype wire

// File: rtl/id_stage_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : id_decode
//  Purpose  : Combinational opcode/funct3 decoder producing control flags,
//             the immediate format and source-register usage.
//  Revision : 1.0  initial release
// ============================================================================
module id_decode
    import riscv_id_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output id_ctrl_t   o_ctrl,
    output imm_sel_t   o_imm_sel,
    output logic       o_use_rs1,
    output logic       o_use_rs2
);

    // Opcode table; unknown opcodes fall to illegal with no other flag set
    always_comb begin
        o_ctrl    = '0;
        o_imm_sel = IMM_NONE;
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b0;
        case (i_opcode)
            c_op_lui, c_op_auipc: begin
                o_imm_sel        = IMM_U;
                o_ctrl.reg_write = 1'b1;
                o_use_rs1        = 1'b0;
            end
            c_op_jal: begin
                o_imm_sel        = IMM_J;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.jump      = 1'b1;
                o_use_rs1        = 1'b0;
            end
            c_op_store: begin
                o_imm_sel        = IMM_S;
                o_ctrl.mem_write = 1'b1;
                o_use_rs2        = 1'b1;
            end
            c_op_branch: begin
                o_imm_sel        = IMM_B;
                o_ctrl.branch    = 1'b1;
                o_use_rs2        = 1'b1;
            end
            c_op_load: begin
                o_imm_sel        = IMM_I;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.mem_read  = 1'b1;
            end
            c_op_jalr: begin
                o_imm_sel        = IMM_I;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.jump      = 1'b1;
            end
            c_op_opimm: begin
                o_ctrl.reg_write = 1'b1;
                if ((i_funct3 == c_f3_slli) || (i_funct3 == c_f3_srli)) begin
                    o_imm_sel = IMM_ISHIFT;
                end else if (i_funct3 == c_f3_sltiu) begin
                    o_imm_sel = IMM_IU;
                end else begin
                    o_imm_sel = IMM_I;
                end
            end
            c_op_op: begin
                o_ctrl.reg_write = 1'b1;
                o_use_rs2        = 1'b1;
            end
            default: begin
                o_ctrl.illegal   = 1'b1;
            end
        endcase
    end

endmodule : id_decode
`default_nettype wire

// File: rtl/id_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage_ctrl
//  Purpose  : Decode-stage sequencer. Accepts fetched instructions on a
//             valid/ready handshake, decodes them into the ID/EX boundary,
//             honours execute back-pressure, flushes on redirect and can
//             insert a one-cycle load-use bubble.
//  Config   : ID_LOAD_USE_STALL_EN - when defined, load-use hazards are
//             detected here and a bubble is inserted; otherwise hazards are
//             left for downstream logic and the STALL state is unreachable.
//  Revision : 1.0  initial release
// ============================================================================
module id_stage_ctrl
    import riscv_id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [24:0]     id_imm_field,
    output logic [2:0]      id_imm_sel,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_branch,
    output logic            id_jump,
    output logic            id_illegal
);

    id_state_t       r_state;
    id_state_t       w_state_nxt;
    logic            w_if_ready;
    logic            w_accept;
    logic            w_hazard;

    id_ctrl_t        w_dec_ctrl;
    imm_sel_t        w_dec_imm_sel;
    logic            w_dec_use_rs1;
    logic            w_dec_use_rs2;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    imm_sel_t        r_imm_sel;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    id_ctrl_t        r_ctrl;

    // The incoming instruction is decoded before it is registered
    id_decode u_decode (
        .i_opcode  (if_instr[6:0]),
        .i_funct3  (if_instr[14:12]),
        .o_ctrl    (w_dec_ctrl),
        .o_imm_sel (w_dec_imm_sel),
        .o_use_rs1 (w_dec_use_rs1),
        .o_use_rs2 (w_dec_use_rs2)
    );

`ifdef ID_LOAD_USE_STALL_EN
    // Outgoing load whose destination feeds a source of the incoming instruction
    assign w_hazard = r_ctrl.mem_read && (r_rd != 5'd0) &&
                      ((w_dec_use_rs1 && (if_instr[19:15] == r_rd)) ||
                       (w_dec_use_rs2 && (if_instr[24:20] == r_rd)));
`else
    // Hazards are resolved downstream; source usage is not needed here
    logic w_hazard_unused;
    assign w_hazard_unused = w_dec_use_rs1 & w_dec_use_rs2;
    assign w_hazard        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready generation and next-state; a redirect overrides everything else
    always_comb begin
        w_state_nxt = r_state;
        w_if_ready  = 1'b0;
        case (r_state)
            ST_EMPTY: w_if_ready = 1'b1;
            ST_FULL:  w_if_ready = ex_ready;
            default:  w_if_ready = 1'b0;
        endcase
        if (flush) begin
            w_if_ready = 1'b0;
        end
        w_accept = if_valid && w_if_ready;

        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) w_state_nxt = ST_FULL;
                end
                ST_FULL: begin
                    if (ex_ready) begin
                        if (w_accept) begin
                            w_state_nxt = w_hazard ? ST_STALL : ST_FULL;
                        end else begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                end
                ST_STALL: begin
                    if (ex_ready) w_state_nxt = ST_FULL;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // ID/EX boundary: cleared on reset/redirect, loaded only on accept
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
            r_imm_sel <= IMM_NONE;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_ctrl    <= '0;
        end else begin
            r_valid <= (w_state_nxt == ST_FULL);
            if (w_accept) begin
                r_pc      <= if_pc;
                r_instr   <= if_instr;
                r_imm_sel <= w_dec_imm_sel;
                r_rs1     <= if_instr[19:15];
                r_rs2     <= if_instr[24:20];
                r_rd      <= if_instr[11:7];
                r_ctrl    <= w_dec_ctrl;
            end
        end
    end

    assign if_ready     = w_if_ready;
    assign id_valid     = r_valid;
    assign id_pc        = r_pc;
    assign id_instr     = r_instr;
    assign id_imm_field = r_instr[31:7];
    assign id_imm_sel   = r_imm_sel;
    assign id_rs1       = r_rs1;
    assign id_rs2       = r_rs2;
    assign id_rd        = r_rd;
    assign id_reg_write = r_ctrl.reg_write;
    assign id_mem_read  = r_ctrl.mem_read;
    assign id_mem_write = r_ctrl.mem_write;
    assign id_branch    = r_ctrl.branch;
    assign id_jump      = r_ctrl.jump;
    assign id_illegal   = r_ctrl.illegal;

endmodule : id_stage_ctrl
`default_nettype wire
